// File: rtl/uart_transmitter.sv
// Byte-to-serial async UART transmitter, 8N1 framing with a CLKS_PER_BIT baud divider.
// Defining UART_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_reg;
  logic [CW-1:0]   baud_cnt_reg;
  logic [2:0]      bit_cnt_reg;
  logic [7:0]      shift_reg;
  logic            tx_reg;
  logic            busy_reg;
`ifdef UART_PARITY_EN
  logic            parity_reg;
`endif

  logic baud_end;
  assign baud_end = (baud_cnt_reg == BAUD_LAST);

  assign tx   = tx_reg;
  assign busy = busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
`ifdef UART_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
          if (load) begin
            shift_reg <= data;
`ifdef UART_PARITY_EN
            parity_reg <= ^data;
`endif
            state_reg <= START;
            tx_reg    <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            state_reg    <= DATA;
            tx_reg       <= shift_reg[0];
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
`ifdef UART_PARITY_EN
              state_reg <= PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              // shift_reg[1] is the bit that lands in position 0 after this shift
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            state_reg    <= STOP;
            tx_reg       <= 1'b1;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end
`endif
        STOP: begin
          // load is ignored here, even on the last stop-bit clock
          if (baud_end) begin
            baud_cnt_reg <= '0;
            state_reg    <= IDLE;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg    <= IDLE;
          baud_cnt_reg <= '0;
          tx_reg       <= 1'b1;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: two instances (1 and 4 clocks per bit) share stimulus;
// a frame-level model queues the expected line level per clock and a monitor pops and compares.
module tb_uart_transmitter;

  localparam int NDUT = 2;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] data = 8'h00;
  logic       check_en = 1'b0;
  logic       tx_w   [NDUT];
  logic       busy_w [NDUT];

  // Each entry is {busy, tx} expected for one clock.
  logic [1:0] exp_q [NDUT][$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      uart_transmitter #(.CLKS_PER_BIT(gi == 0 ? 1 : 4)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .data (data),
        .tx   (tx_w[gi]),
        .busy (busy_w[gi])
      );
    end
  endgenerate

  function automatic int cpb_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // A frame is NBITS bit-periods, then one mandatory idle clock before the next acceptance.
  task automatic push_frame(input int i, input logic [7:0] d);
    logic lvl [NBITS];
    lvl[0] = 1'b0;
    for (int k = 0; k < 8; k++) lvl[k+1] = d[k];
`ifdef UART_PARITY_EN
    lvl[9] = ^d;
`endif
    lvl[NBITS-1] = 1'b1;
    for (int b = 0; b < NBITS; b++)
      for (int c = 0; c < cpb_of(i); c++)
        exp_q[i].push_back({1'b1, lvl[b]});
    exp_q[i].push_back(2'b01);
    $display("[TB] dut%0d (cpb=%0d) accepted byte 0x%02h at %0t", i, cpb_of(i), d, $time);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (rst) exp_q[i].delete();
      else if (load && exp_q[i].size() == 0) push_frame(i, data);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NDUT; i++) begin
        logic [1:0] e;
        e = (exp_q[i].size() > 0) ? exp_q[i].pop_front() : 2'b01;
        tests++;
        if ({busy_w[i], tx_w[i]} !== e) begin
          fails++;
          $display("FAIL line_cpb%0d t=%0t busy/tx got %b%b expected %b",
                   cpb_of(i), $time, busy_w[i], tx_w[i], e);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    load = 1'b1;
    data = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    #1 check_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(5);

    send(8'hAA);
    idle(15);
    send(8'h5C);
    idle(20);

    // load while busy must be ignored
    send(8'h00);
    idle(2);
    send(8'hFF);
    idle(60);

    // reset mid-frame, then a clean frame
    send(8'hAA);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h5C);
    idle(60);

    send(8'h01);
    idle(60);

    // rst and load on the same edge: rst wins
    @(negedge clk);
    rst = 1'b1;
    load = 1'b1;
    data = 8'h33;
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    idle(5);

    // load held high with data changing every clock
    @(negedge clk);
    load = 1'b1;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      data = 8'($urandom);
    end
    load = 1'b0;
    idle(60);

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 63) == 0);
      load = ($urandom_range(0, 3) == 0);
      data = 8'($urandom);
    end
    rst  = 1'b0;
    load = 1'b0;
    idle(60);

    for (int i = 0; i < NDUT; i++) begin
      tests++;
      if (exp_q[i].size() != 0) begin
        fails++;
        $display("FAIL drain_cpb%0d pending %0d expected 0", cpb_of(i), exp_q[i].size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
